// File: rtl/cr16_controller.sv
// cr16_controller: multi-cycle fetch/decode/execute control unit for the CR16 datapath.
// Optional `define SINGLE_STEP_EN adds I_STEP and a STEP_WAIT state between instructions.
module cr16_controller #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                I_CLK,
  input  logic                I_NRESET,
  input  logic                I_START,
`ifdef SINGLE_STEP_EN
  input  logic                I_STEP,
`endif
  output logic [PC_WIDTH-1:0] O_IMEM_ADDRESS,
  output logic                O_IMEM_READ,
  input  logic [15:0]         I_IMEM_DATA,
  input  logic                I_IMEM_VALID,
  output logic                O_DATAPATH_NRESET,
  output logic [15:0]         O_REG_WRITE_ENABLE,
  output logic [3:0]          O_REG_A_SELECT,
  output logic [3:0]          O_REG_B_SELECT,
  output logic [15:0]         O_IMMEDIATE,
  output logic                O_IMMEDIATE_SELECT,
  output logic [3:0]          O_OPCODE,
  output logic [PC_WIDTH-1:0] O_PC,
  output logic                O_BUSY,
  output logic                O_HALTED
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_HALTED
`ifdef SINGLE_STEP_EN
    , S_STEP_WAIT
`endif
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_next_state;
  state_t              w_after_instr;
  logic [PC_WIDTH-1:0] r_pc;
  logic [15:0]         r_ir;
  logic [3:0]          w_class;
  logic [3:0]          w_rdest;
  logic [3:0]          w_ext;
  logic [3:0]          w_rsrc;

  assign w_class = r_ir[15:12];
  assign w_rdest = r_ir[11:8];
  assign w_ext   = r_ir[7:4];
  assign w_rsrc  = r_ir[3:0];

  assign O_IMEM_ADDRESS = r_pc;
  assign O_PC           = r_pc;

`ifdef SINGLE_STEP_EN
  assign w_after_instr = S_STEP_WAIT;
`else
  assign w_after_instr = S_FETCH;
`endif

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_ir    <= 16'h0000;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_CLEAR) begin
        r_pc <= RESET_PC;
      end else if (r_state == S_EXECUTE) begin
        r_pc <= r_pc + PC_ONE;
      end
      if (r_state == S_FETCH && I_IMEM_VALID) begin
        r_ir <= I_IMEM_DATA;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (I_START) w_next_state = S_CLEAR;
      S_CLEAR:   w_next_state = w_after_instr;
      S_FETCH:   if (I_IMEM_VALID) w_next_state = S_DECODE;
      S_DECODE:  w_next_state = (w_class == 4'hF) ? S_HALTED : S_EXECUTE;
      S_EXECUTE: w_next_state = w_after_instr;
      S_HALTED:  if (I_START) w_next_state = S_CLEAR;
`ifdef SINGLE_STEP_EN
      S_STEP_WAIT: if (I_STEP) w_next_state = S_FETCH;
`endif
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Moore outputs: operand controls are presented in both DECODE and EXECUTE so the
  // datapath sees stable selects a cycle before the write strobe.
  always_comb begin
    O_DATAPATH_NRESET  = 1'b1;
    O_IMEM_READ        = 1'b0;
    O_REG_WRITE_ENABLE = 16'h0000;
    O_REG_A_SELECT     = 4'h0;
    O_REG_B_SELECT     = 4'h0;
    O_IMMEDIATE        = 16'h0000;
    O_IMMEDIATE_SELECT = 1'b0;
    O_OPCODE           = 4'h0;
    O_BUSY             = 1'b0;
    O_HALTED           = 1'b0;
    case (r_state)
      S_CLEAR: begin
        O_DATAPATH_NRESET = 1'b0;
        O_BUSY            = 1'b1;
      end
      S_FETCH: begin
        O_IMEM_READ = 1'b1;
        O_BUSY      = 1'b1;
      end
      S_DECODE, S_EXECUTE: begin
        O_BUSY = 1'b1;
        if (w_class != 4'hF) begin
          O_REG_A_SELECT = w_rdest;
          if (w_class == 4'h0) begin
            O_REG_B_SELECT = w_rsrc;
            O_OPCODE       = w_ext;
          end else begin
            O_IMMEDIATE        = {{8{r_ir[7]}}, r_ir[7:0]};
            O_IMMEDIATE_SELECT = 1'b1;
            O_OPCODE           = (w_class == 4'h1) ? 4'h0 : w_class;
          end
          if (r_state == S_EXECUTE) begin
            O_REG_WRITE_ENABLE = 16'h0001 << w_rdest;
          end
        end
      end
      S_HALTED: O_HALTED = 1'b1;
`ifdef SINGLE_STEP_EN
      S_STEP_WAIT: O_BUSY = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: doc/cr16_controller.md
Name: cr16_controller

Overview:
Multi-cycle fetch/decode/execute control unit for the CR16 datapath. Fetches 16-bit instructions from an instruction-memory read port that uses a valid handshake, then decodes them. Drives the datapath control bus: one-hot register write enable, A/B selects, immediate, immediate select, ALU opcode and datapath reset. It replaces hard-wired demo sequencing as the block directly upstream of the datapath.

Parameters:
PC_WIDTH, 8, width of the program counter and O_IMEM_ADDRESS.
RESET_PC, 0, PC value loaded on reset and on every start.

Ports:
I_CLK  input  1  clock
I_NRESET  input  1  asynchronous active-low reset
I_START  input  1  single-cycle pulse; starts or restarts execution
O_IMEM_ADDRESS  output  PC_WIDTH  instruction fetch address
O_IMEM_READ  output  1  fetch request
I_IMEM_DATA  input  16  instruction word, valid when I_IMEM_VALID=1
I_IMEM_VALID  input  1  instruction-memory data-valid handshake
O_DATAPATH_NRESET  output  1  active-low datapath register clear
O_REG_WRITE_ENABLE  output  16  one-hot register write enable
O_REG_A_SELECT  output  4  binary A operand select
O_REG_B_SELECT  output  4  binary B operand select
O_IMMEDIATE  output  16  immediate operand
O_IMMEDIATE_SELECT  output  1  1 = B operand replaced by immediate
O_OPCODE  output  4  ALU opcode
O_PC  output  PC_WIDTH  current program counter
O_BUSY  output  1  high in CLEAR/FETCH/DECODE/EXECUTE
O_HALTED  output  1  high in HALTED

Behaviour:
- Clocking: one clock, I_CLK. Reset: I_NRESET, asynchronous, active-low. Reset forces state=IDLE, PC=RESET_PC, IR=16'h0000.
- Outputs are Moore-decoded from state and IR. Reset/IDLE values: all outputs 0, except O_DATAPATH_NRESET=1 and O_IMEM_ADDRESS=O_PC=RESET_PC.
- Instruction encoding: IR[15:12]=class, IR[11:8]=Rdest, IR[7:4]=ext/ImmHi, IR[3:0]=Rsrc/ImmLo.
  - Class 0 (RR): A=Rdest, B=Rsrc, O_OPCODE=IR[7:4], O_IMMEDIATE_SELECT=0, O_IMMEDIATE=0.
  - Class 1 (ADDI): A=Rdest, O_OPCODE=0, O_IMMEDIATE_SELECT=1.
  - Classes 2..E (RI): A=Rdest, O_OPCODE=class, O_IMMEDIATE_SELECT=1.
  - Classes 1..E: O_IMMEDIATE={{8{IR[7]}},IR[7:0]}, B select=0.
  - Class F: HALT.
- States:
  - IDLE: I_START -> CLEAR. All other inputs ignored.
  - CLEAR: O_DATAPATH_NRESET=0 for exactly one cycle; PC<=RESET_PC; -> FETCH.
  - FETCH: O_IMEM_READ=1, O_IMEM_ADDRESS=PC held stable. Remain in FETCH until I_IMEM_VALID=1; then IR<=I_IMEM_DATA and -> DECODE. Valid in the first FETCH cycle means zero wait states.
  - DECODE: selects/immediate/opcode driven from IR, write enable 0. Class F -> HALTED; otherwise -> EXECUTE.
  - EXECUTE: same controls as DECODE plus O_REG_WRITE_ENABLE=16'h1<<Rdest for this single cycle. PC<=PC+1, wrapping modulo 2^PC_WIDTH with no fault. -> FETCH.
  - HALTED: O_HALTED=1, write enable 0; I_START -> CLEAR.
- Timing: CPI = 3 + memory wait cycles. Exactly one write-enable bit is set, for exactly one cycle, per non-HALT instruction.
- I_START is ignored in CLEAR/FETCH/DECODE/EXECUTE.
- I_IMEM_VALID is ignored outside FETCH.
- Reset mid-operation: all outputs return to IDLE values immediately, without waiting for a clock. A pending fetch is abandoned.

Optional Feature:
SINGLE_STEP_EN
- Defined:
  - Adds input I_STEP (1 bit) and state STEP_WAIT.
  - CLEAR and EXECUTE go to STEP_WAIT instead of FETCH.
  - STEP_WAIT drives IDLE-equivalent controls with O_BUSY=1, and moves to FETCH on I_STEP=1.
- Undefined: no I_STEP port, no STEP_WAIT state; transitions as above.

Test Plan:
1. Reset: assert I_NRESET=0 -> O_REG_WRITE_ENABLE=0, O_IMEM_READ=0, O_DATAPATH_NRESET=1, O_PC=0, O_BUSY=0, O_HALTED=0.
2. Program 0x1101, 0x1201, 0x0102, 0xF000, zero wait states, pulse I_START:
   - O_DATAPATH_NRESET low exactly 1 cycle.
   - Write enables 0x0002 (imm 1), 0x0004 (imm 1), 0x0002 (A=1, B=2, opcode 0, imm_sel 0), each a single cycle spaced 3 cycles apart.
   - O_HALTED=1 with O_PC=3.
3. Sign extension: 0x13FF -> O_IMMEDIATE=16'hFFFF, O_OPCODE=0, A=3. 0x5A7F -> O_IMMEDIATE=16'h007F, O_OPCODE=5, write enable 16'h0400.
4. Wait states: I_IMEM_VALID delayed 2 cycles -> O_IMEM_ADDRESS/O_IMEM_READ held 3 cycles, instruction period 5 cycles.
5. PC_WIDTH=2, memory all 0x0000 -> addresses 0,1,2,3,0,1 fetched in order. Each instruction produces write enable 0x0001; no halt.
6. Drop I_NRESET during EXECUTE -> write enable falls to 0 asynchronously, state IDLE, PC=RESET_PC. I_START afterwards restarts cleanly. With SINGLE_STEP_EN, no FETCH until I_STEP pulses.
